// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
//
// Instruction-fetch stage with a small prefetch queue. It owns the fetch PC,
// talks to instruction memory over a req/ack handshake (wait states allowed),
// buffers returned words in a circular queue and presents one instruction per
// cycle to the IF/ID register. It honours the ID load-use stall and the
// branch/jump redirect.
//
// Ports:
//   Clock, Reset         clock, asynchronous active-high reset
//   pcsource[1:0]        00/11 sequential, 01 branch (bpc), 10 jump (jpc)
//   bpc, jpc             redirect targets
//   stall                hold the presented instruction
//   imem_req, imem_addr  fetch request / word address
//   imem_ack, imem_rdata fetch completion / instruction word
//   PC, if_pc4           address of presented instruction and PC+4
//   if_inst, if_valid    instruction to IF/ID (0 when not valid)

module if_prefetch_stage #(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  // Architectural state
  logic [31:0]   fpc_reg;        // next fetch address
  logic [31:0]   req_addr_reg;   // address of the outstanding request
  logic          pending_reg;    // a request is outstanding
  logic          discard_reg;    // outstanding response belongs to a flushed path
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;

  // Queue storage; no reset needed since entries are only read when valid
  logic [31:0] q_pc   [QDEPTH];
  logic [31:0] q_inst [QDEPTH];

  logic        redir;
  logic        has_head;
  logic        pop;
  logic        issue;
  logic        ack_ok;
  logic        push;
  logic [31:0] pc_cur;

  always_comb begin
    // Redirect is ignored while ID is stalled
    redir    = ~stall & ((pcsource == 2'b01) | (pcsource == 2'b10));
    has_head = (count_reg != '0);
    if_valid = has_head & ~redir;
    pop      = if_valid & ~stall;
    if_inst  = if_valid ? q_inst[rd_ptr_reg] : 32'h0;
    pc_cur   = has_head ? q_pc[rd_ptr_reg] : fpc_reg;
    PC       = pc_cur;
    if_pc4   = pc_cur + 32'd4;

    // A new request reserves a queue slot: issue only if there is room now
    // or the head leaves this cycle. An outstanding request keeps its
    // address frozen until acknowledged, whatever stall/redirect do.
    issue     = ~pending_reg & ~redir & ~Reset & ((count_reg < QFULL) | pop);
    imem_req  = pending_reg | issue;
    imem_addr = pending_reg ? req_addr_reg : fpc_reg;

    ack_ok = imem_req & imem_ack;
    push   = ack_ok & ~discard_reg & ~redir;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      fpc_reg      <= RESET_PC;
      req_addr_reg <= RESET_PC;
      pending_reg  <= 1'b0;
      discard_reg  <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      pending_reg  <= imem_req & ~imem_ack;
      req_addr_reg <= imem_addr;
      if (redir) begin
        rd_ptr_reg  <= '0;
        wr_ptr_reg  <= '0;
        count_reg   <= '0;
        fpc_reg     <= (pcsource == 2'b01) ? bpc : jpc;
        // An in-flight request for the old path must have its data dropped
        discard_reg <= pending_reg & ~imem_ack;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
          fpc_reg    <= imem_addr + 32'd4;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
        if (push & ~pop) begin
          count_reg <= count_reg + CW'(1);
        end else if (~push & pop) begin
          count_reg <= count_reg - CW'(1);
        end
        if (ack_ok & discard_reg) begin
          discard_reg <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      q_pc[wr_ptr_reg]   <= imem_addr;
      q_inst[wr_ptr_reg] <= imem_rdata;
    end
  end

endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Instruction-fetch stage with a small prefetch queue, sitting directly upstream of the IF/ID pipeline register of the five-stage pipelined CPU. It owns the fetch PC and issues requests to an instruction memory over a req/ack handshake, so the memory may insert wait states. Fetched words are buffered and presented to IF/ID one per cycle. It honours the ID-stage load-use stall and the branch/jump redirect (`pcsource`, `bpc`, `jpc`).

## Interface
- `QDEPTH`, 4: prefetch queue entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high; clears all state immediately.
- `pcsource` in 2: from ID. 00 = sequential, 01 = branch taken (`bpc`), 10 = jump (`jpc`), 11 = treated as 00.
- `bpc` in 32: branch target.
- `jpc` in 32: jump target.
- `stall` in 1: ID hazard stall; hold the presented instruction.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: word-aligned fetch address.
- `imem_ack` in 1: request completed; `imem_rdata` is valid this cycle.
- `imem_rdata` in 32: instruction word.
- `PC` out 32: address of the presented instruction (the fetch PC when the queue is empty).
- `if_pc4` out 32: `PC` + 4, modulo 2^32.
- `if_inst` out 32: instruction to IF/ID; 32'h0 (nop) when there is no valid instruction or it is squashed.
- `if_valid` out 1: `if_inst` holds a real fetched instruction.

## Operation
- State:
  - `fpc`: next fetch address.
  - Circular queue of {pc, inst} with rd/wr pointers and a count 0..QDEPTH.
  - `pending`: request outstanding.
  - `discard`: response must be dropped.
- Redirect: `redir = ~stall & (pcsource==01 | pcsource==10)`. While `stall=1`, `pcsource` is ignored.
- Pop: `pop = if_valid & ~stall & ~redir`. The head is consumed by IF/ID.
- Presentation:
  - `if_valid = (count != 0) & ~redir`.
  - `if_inst` = head inst when `if_valid`, else 0.
  - `PC`/`if_pc4` come from the head pc when `count != 0`, else from `fpc`.
- Request issue:
  - If `pending`, `imem_req` stays 1 and `imem_addr` stays frozen until ack, regardless of stall or redirect.
  - Otherwise a new request is issued when `~redir & ~Reset & (count < QDEPTH | pop)`, with `imem_req=1` and `imem_addr=fpc`.
  - At most one request is outstanding. Space is reserved at issue, so an acked word can always be pushed.
- Ack without `discard` and without `redir` in the same cycle: push {`imem_addr`, `imem_rdata`} and set `fpc <= imem_addr + 4`.
  - An ack in the same cycle as the request (zero-wait memory) is legal.
  - `pending` is set only when `req & ~ack`, and cleared on ack.
- Ack with `discard`, or in a `redir` cycle: the word is dropped and `discard` is cleared.
- Redirect cycle:
  - Flush the queue (count = 0, pointers = 0).
  - `fpc <=` `bpc` (01) or `jpc` (10).
  - If a request is pending and not acked this cycle, set `discard`.
  - No new request is issued in the redirect cycle.
- Push and pop in the same cycle with a full queue is legal; count stays QDEPTH.
- `stall` alone never changes the queue or `fpc`; fetching continues until the queue is full.

## Timing
- Reset values (held while `Reset=1`):
  - `imem_req=0`, `imem_addr=RESET_PC`.
  - `if_valid=0`, `if_inst=0`.
  - `PC=RESET_PC`, `if_pc4=RESET_PC+4`.
  - Queue empty, `pending=0`, `discard=0`.
- Reset asserted mid-request: the request is abandoned immediately. After release, the first request goes to `RESET_PC` in the first cycle.
- Fetch latency: with a zero-wait memory, an instruction acked in cycle t is presented in cycle t+1. Each memory wait state adds one cycle.
- Steady-state throughput with a zero-wait memory: one instruction per cycle, with no bubbles.
- Redirect penalty with a zero-wait memory:
  - Redirect in cycle t.
  - Target requested in t+1.
  - Target presented in t+2.
  - `if_inst=0` in t and t+1.
- Redirect while a request is pending: the target request follows the cycle after the discarded ack.
- Address arithmetic is 32-bit unsigned with silent wrap: 32'hFFFF_FFFC + 4 = 0.

## Test plan
- Reset release, zero-wait memory returning `addr ^ 32'hA5A5_0000` -> `imem_addr` reads 0, 4, 8, ... one per cycle. `if_valid` rises one cycle after release, and `PC`/`if_inst` track at one per cycle.
- Stall held 6 cycles, QDEPTH=4 -> `if_inst` and `PC` frozen throughout. Exactly 4 further requests complete (3 if the head is already in the queue), then `imem_req` drops to 0. On release the stream resumes with no duplicates or gaps.
- Branch with `pcsource=01`, `bpc=32'h40` at cycle t -> `if_inst=0` in t and t+1, `imem_addr=32'h40` in t+1, `PC=32'h40` with `if_valid=1` in t+2. The queue contents from before the branch are never presented.
- Memory with 3 wait states and a jump to `32'h100` during the pending request for `32'h20` -> `imem_addr` stays `32'h20` until ack. That data is dropped, then `32'h100` is requested the following cycle.
- `stall=1` together with `pcsource=10` -> no redirect and no flush; the redirect takes effect in the first cycle `stall=0`.
- Reset asserted 1 cycle while `pending=1` and the queue is full -> all outputs return to their reset values asynchronously. Refetch starts from `RESET_PC`, and a late ack from the old request is ignored.
